// File: rtl/stream_mux_pkg.sv
// Shared sizing helpers for the stream mux: select width and reset pointer.
package stream_mux_pkg;

  function automatic int sel_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Pointer parks on the last channel so the first search starts at channel 0.
  function automatic int rst_ptr(input int n);
    return n - 1;
  endfunction

endpackage

// File: rtl/stream_mux_rr_arbiter.sv
// Combinational rotating-priority arbiter, zero latency; searches from ptr+1 (advance=1) or from ptr.
// No backpressure of its own: the caller qualifies grant with its load enable.
module rr_arbiter
  import stream_mux_pkg::*;
#(
  parameter int N = 3,
  localparam int SW = sel_w(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [SW-1:0] ptr_i,
  input  logic          advance_i,
  output logic [N-1:0]  grant_o,
  output logic [SW-1:0] idx_o
);

  int            c;
  logic [SW-1:0] cidx;
  logic          found;

  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    found   = 1'b0;
    c       = 0;
    cidx    = '0;
    for (int k = 0; k < N; k++) begin
      c    = (int'(ptr_i) + int'(advance_i) + k) % N;
      cidx = SW'(c);
      if (!found && req_i[cidx]) begin
        grant_o[cidx] = 1'b1;
        idx_o         = cidx;
        found         = 1'b1;
      end
    end
  end

endmodule

// File: rtl/stream_mux_rr.sv
// N_IN-to-1 stream mux, round-robin or forced select; macro STREAM_MUX_PKT_LOCK_EN adds packet locking.
// Output registered (1 cycle, 1 beat/cycle); every in_ready drops while an output beat is held.
module stream_mux_rr
  import stream_mux_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int N_IN  = 3,
  localparam int SEL_W = sel_w(N_IN)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data [N_IN-1:0],
  input  logic [N_IN-1:0]  in_valid,
  input  logic [N_IN-1:0]  in_last,
  output logic [N_IN-1:0]  in_ready,
  input  logic             force_en,
  input  logic [SEL_W-1:0] force_sel,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  output logic             out_last,
  output logic [SEL_W-1:0] out_sel,
  input  logic             out_ready
);

  localparam logic [SEL_W-1:0] PTR_RST = SEL_W'(rst_ptr(N_IN));

  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [SEL_W-1:0] out_sel_q, out_sel_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic             out_last_q, out_last_d;

  logic [N_IN-1:0]  tgt_mask, arb_req, grant;
  logic [SEL_W-1:0] tgt, arb_ptr, arb_idx;
  logic             pinned, upd_ptr, ld, xfer;

`ifdef STREAM_MUX_PKT_LOCK_EN
  logic             lock_q, lock_d;
  logic [SEL_W-1:0] lock_ch_q, lock_ch_d;

  // An open packet overrides both modes until its last beat transfers.
  assign pinned  = force_en || lock_q;
  assign tgt     = lock_q ? lock_ch_q : force_sel;
  assign upd_ptr = !force_en || lock_q;
`else
  assign pinned  = force_en;
  assign tgt     = force_sel;
  assign upd_ptr = !force_en;
`endif

  // An out-of-range target matches no channel, so nothing is granted.
  always_comb begin
    tgt_mask = '0;
    for (int i = 0; i < N_IN; i++) tgt_mask[i] = (tgt == SEL_W'(i));
  end

  assign arb_req = pinned ? (in_valid & tgt_mask) : in_valid;
  assign arb_ptr = pinned ? tgt : ptr_q;

  rr_arbiter #(.N(N_IN)) u_arb (
    .req_i    (arb_req),
    .ptr_i    (arb_ptr),
    .advance_i(!pinned),
    .grant_o  (grant),
    .idx_o    (arb_idx)
  );

  assign ld       = !out_valid_q || out_ready;
  assign in_ready = rst_n ? (grant & {N_IN{ld}}) : '0;
  assign xfer     = |in_ready;

  always_comb begin
    ptr_d       = ptr_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    out_sel_d   = out_sel_q;
    out_valid_d = out_valid_q;
`ifdef STREAM_MUX_PKT_LOCK_EN
    lock_d      = lock_q;
    lock_ch_d   = lock_ch_q;
`endif
    if (xfer) begin
      out_valid_d = 1'b1;
      out_data_d  = in_data[arb_idx];
      out_last_d  = in_last[arb_idx];
      out_sel_d   = arb_idx;
      if (upd_ptr) ptr_d = arb_idx;
`ifdef STREAM_MUX_PKT_LOCK_EN
      lock_d    = !in_last[arb_idx];
      lock_ch_d = arb_idx;
`endif
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q       <= PTR_RST;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_sel_q   <= '0;
      out_valid_q <= 1'b0;
`ifdef STREAM_MUX_PKT_LOCK_EN
      lock_q      <= 1'b0;
      lock_ch_q   <= '0;
`endif
    end else begin
      ptr_q       <= ptr_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      out_sel_q   <= out_sel_d;
      out_valid_q <= out_valid_d;
`ifdef STREAM_MUX_PKT_LOCK_EN
      lock_q      <= lock_d;
      lock_ch_q   <= lock_ch_d;
`endif
    end
  end

  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign out_sel   = out_sel_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_stream_mux_rr.sv
// Scoreboard bench for stream_mux_rr (WIDTH=8, N_IN=3): expected beats queued at input transfer.
module tb_stream_mux_rr;
  localparam int N = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [7:0] in_data [N-1:0];
  logic [N-1:0] in_valid, in_last, in_ready;
  logic       force_en;
  logic [1:0] force_sel;
  logic [7:0] out_data;
  logic       out_valid, out_last, out_ready;
  logic [1:0] out_sel;

  always #5 clk = ~clk;

  stream_mux_rr #(.WIDTH(8), .N_IN(N)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready), .force_en(force_en), .force_sel(force_sel), .out_data(out_data),
    .out_valid(out_valid), .out_last(out_last), .out_sel(out_sel), .out_ready(out_ready)
  );

  int n_chk = 0;
  int n_err = 0;
  logic [10:0] sb[$];
  int obs_sel[$];
  int obs_data[$];
  int m_ptr = 2;
  bit m_ov = 1'b0;
  bit m_lock = 1'b0;
`ifdef STREAM_MUX_PKT_LOCK_EN
  int m_lock_ch = 0;
`endif
  int cnt[N];

  task automatic check_eq(input string tag, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic int m_grant(input logic [N-1:0] v);
`ifdef STREAM_MUX_PKT_LOCK_EN
    if (m_lock) return v[m_lock_ch] ? m_lock_ch : -1;
`endif
    if (force_en) return (int'(force_sel) < N && v[force_sel]) ? int'(force_sel) : -1;
    for (int k = 1; k <= N; k++) begin
      int c;
      c = (m_ptr + k) % N;
      if (v[c]) return c;
    end
    return -1;
  endfunction

  // Reference model and scoreboard, evaluated on the falling edge.
  always @(negedge clk) begin
    int g;
    bit ld;
    logic [10:0] e;
    if (rst_n) begin
      g  = m_grant(in_valid);
      ld = !m_ov || out_ready;
      check_eq("in_ready", int'(in_ready), (g >= 0 && ld) ? (1 << g) : 0);
      check_eq("out_valid", int'(out_valid), int'(m_ov));
      if (out_valid && out_ready) begin
        if (sb.size() == 0) check_eq("sb_depth", sb.size(), 1);
        else begin
          e = sb.pop_front();
          check_eq("out_sel", int'(out_sel), int'(e[10:9]));
          check_eq("out_data", int'(out_data), int'(e[8:1]));
          check_eq("out_last", int'(out_last), int'(e[0]));
          obs_sel.push_back(int'(out_sel));
          obs_data.push_back(int'(out_data));
        end
      end
      if (g >= 0 && ld) begin
        sb.push_back({2'(g), in_data[g], in_last[g]});
        cnt[g]++;
        if (!(force_en && !m_lock)) m_ptr = g;
`ifdef STREAM_MUX_PKT_LOCK_EN
        m_lock    = !in_last[g];
        m_lock_ch = g;
`endif
        m_ov = 1'b1;
      end else if (m_ov && out_ready) begin
        m_ov = 1'b0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    check_eq("rst_out_valid", int'(out_valid), 0);
    check_eq("rst_out_data", int'(out_data), 0);
    check_eq("rst_out_last", int'(out_last), 0);
    check_eq("rst_out_sel", int'(out_sel), 0);
    check_eq("rst_in_ready", int'(in_ready), 0);
    sb.delete(); obs_sel.delete(); obs_data.delete();
    m_ptr = 2; m_ov = 1'b0; m_lock = 1'b0;
    foreach (cnt[i]) cnt[i] = 0;
    @(posedge clk);
    check_eq("rst_in_ready_hold", int'(in_ready), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic wait_beats(input int n, input int budget);
    for (int i = 0; i < budget && obs_sel.size() < n; i++) step();
    check_eq("beats_seen", int'(obs_sel.size() >= n), 1);
  endtask

  task automatic set_const_data();
    for (int i = 0; i < N; i++) in_data[i] = 8'h10 + 8'(i);
    in_last = '1;
  endtask

  task automatic set_pkt_data();
    in_data[0] = 8'h10;
    in_data[1] = 8'h11;
    in_data[2] = 8'h20 + 8'(cnt[2]);
    in_last    = {cnt[2] % 3 == 2, 2'b11};
  endtask

  int exp_rr[4] = '{0, 1, 2, 0};
`ifdef STREAM_MUX_PKT_LOCK_EN
  int exp_pk[4] = '{2, 2, 2, 0};
`else
  int exp_pk[4] = '{2, 0, 1, 2};
`endif

  initial begin
    set_const_data();
    in_valid = 3'b111; force_en = 1'b0; force_sel = 2'd0; out_ready = 1'b1;

    // Round-robin over all three channels.
    do_reset();
    wait_beats(4, 20);
    for (int i = 0; i < 4; i++) begin
      check_eq("rr_sel", obs_sel[i], exp_rr[i]);
      check_eq("rr_data", obs_data[i], 8'h10 + exp_rr[i]);
    end

    // Held output beat blocks every input.
    in_valid = 3'b101; out_ready = 1'b0;
    do_reset();
    for (int i = 0; i < 10 && !out_valid; i++) step();
    check_eq("hold_vld", int'(out_valid), 1);
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("hold_data", int'(out_data), 8'h10);
      check_eq("hold_rdy", int'(in_ready), 0);
    end
    out_ready = 1'b1;
    wait_beats(2, 10);
    check_eq("hold_sel0", obs_sel[0], 0);
    check_eq("hold_sel1", obs_sel[1], 2);
    check_eq("hold_data1", obs_data[1], 8'h12);

    // Static select, then an out-of-range select.
    in_valid = 3'b000;
    repeat (3) step();
    obs_sel.delete(); obs_data.delete();
    force_en = 1'b1; force_sel = 2'd1; in_valid = 3'b111;
    repeat (8) step();
    check_eq("force_beats", int'(obs_sel.size() >= 5), 1);
    foreach (obs_sel[i]) check_eq("force_sel", obs_sel[i], 1);
    force_sel = 2'd3;
    repeat (3) step();
    check_eq("force_oob_vld", int'(out_valid), 0);
    check_eq("force_oob_rdy", int'(in_ready), 0);
    force_en = 1'b0; force_sel = 2'd0;

    // Three-beat packet on channel 2 while channels 0/1 also request.
    in_valid = 3'b100;
    set_pkt_data();
    do_reset();
    for (int i = 0; i < 20 && obs_sel.size() < 4; i++) begin
      step();
      set_pkt_data();
      if (cnt[2] >= 1) in_valid = 3'b111;
    end
    check_eq("pkt_beats", int'(obs_sel.size() >= 4), 1);
    for (int i = 0; i < 4; i++) check_eq("pkt_sel", obs_sel[i], exp_pk[i]);

    // Reset with a beat in flight mid-packet.
    check_eq("pre_rst_vld", int'(out_valid), 1);
    do_reset();
    wait_beats(1, 10);
    check_eq("post_rst_sel", obs_sel[0], 0);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      in_valid  = 3'($urandom);
      in_last   = 3'($urandom);
      for (int j = 0; j < N; j++) in_data[j] = 8'($urandom);
      out_ready = ($urandom % 4) != 0;
      force_en  = ($urandom % 8) == 0;
      force_sel = 2'($urandom % 4);
      step();
    end
    in_valid = 3'b000; force_en = 1'b0; out_ready = 1'b1;
    repeat (4) step();
    check_eq("drain_sb", sb.size(), 0);
    check_eq("drain_vld", int'(out_valid), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/stream_mux_rr.md
STREAM_MUX_RR -- requirements
Module: stream_mux_rr

Interface
REQ-001 Parameter WIDTH, default 8, data width in bits per channel (>=1).
REQ-002 Parameter N_IN, default 3, number of input channels (>=2).
REQ-003 Port clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 Port in_data  input  N_IN x WIDTH (unpacked array [N_IN-1:0])  per-channel data.
REQ-006 Port in_valid  input  N_IN  per-channel valid.
REQ-007 Port in_last  input  N_IN  per-channel end-of-packet marker.
REQ-008 Port in_ready  output  N_IN  per-channel ready.
REQ-009 Port force_en  input  1  1 = static select mode, 0 = round-robin mode.
REQ-010 Port force_sel  input  SEL_W = $clog2(N_IN)  channel chosen in static mode.
REQ-011 Port out_data  output  WIDTH  registered selected data.
REQ-012 Port out_valid  output  1  out_data holds an untransferred beat.
REQ-013 Port out_last  output  1  registered in_last of the source beat.
REQ-014 Port out_sel  output  SEL_W  index of the channel that supplied the current output beat.
REQ-015 Port out_ready  input  1  downstream ready.

Function
REQ-016 Transfer: in channel i when in_valid[i] && in_ready[i]; out when out_valid && out_ready.
REQ-017 Load enable: ld = !out_valid || out_ready; in_ready[i] = grant[i] && ld, at most one grant bit set.
REQ-018 On input transfer, out_data/out_last/out_sel load next cycle and out_valid = 1; latency 1 cycle; throughput 1 beat/cycle.
REQ-019 If out_valid && !out_ready, out_data/out_last/out_sel hold stable and all in_ready = 0.
REQ-020 Output transfer with no input transfer in the same cycle clears out_valid; simultaneous in/out transfer keeps out_valid = 1 with new beat.
REQ-021 Round-robin: grant the first valid channel searching from (ptr+1) mod N_IN upward with wrap; ptr updates to the granted index only on an input transfer.
REQ-022 No valid channel: no grant, ptr unchanged.
REQ-023 Static mode: grant = force_sel if in_valid[force_sel]; force_sel >= N_IN grants nothing; ptr not updated.
REQ-024 force_en/force_sel changes take effect the same cycle (combinational grant); a held output beat is unaffected.
REQ-025 Grant computation is combinational from in_valid, mode and state; no valid-to-ready dependency on out_valid of other channels.

Reset
REQ-026 rst_n low: out_valid = 0, out_data = 0, out_last = 0, out_sel = 0, ptr = N_IN-1 (first grant searches from 0), lock cleared, immediately and asynchronously.
REQ-027 Reset mid-packet or with a held beat discards that beat; no beat is output after deassertion until a new input transfer.
REQ-028 in_ready = 0 throughout reset.

Configuration
REQ-029 Macro STREAM_MUX_PKT_LOCK_EN defined: after an input transfer with in_last = 0, grant locks to that channel (both modes) until a transfer from it with in_last = 1; force_en/force_sel ignored while locked.
REQ-030 Macro undefined: no lock state; arbitration is per beat; in_last still propagates to out_last.

Structure
REQ-031 Package stream_mux_pkg holds the sel-width function (clog2 wrapper, minimum 1) and the reset-pointer constant expression.
REQ-032 Sub-module rr_arbiter (parameter N; inputs req, ptr, advance; output one-hot grant and index) implements REQ-021/022; stream_mux_rr instantiates it once.

Verification (WIDTH=8, N_IN=3)
REQ-033 Reset, then in_valid=3'b111, data 0x10/0x11/0x12, out_ready=1 -> outputs 0x10,0x11,0x12,0x10 on consecutive cycles, out_sel 0,1,2,0.
REQ-034 in_valid=3'b101 held, out_ready=0 for 3 cycles after first beat -> out_data stays 0x10, in_ready=0 throughout; on release next beat is channel 2.
REQ-035 force_en=1, force_sel=1, all valid -> only channel 1 beats output; force_sel=3 -> in_ready=0, out_valid drops after drain.
REQ-036 With STREAM_MUX_PKT_LOCK_EN: channel 2 sends 3 beats, last on 3rd, channels 0/1 valid -> output 2,2,2 then 0; without macro -> 2,0,1,2.
REQ-037 rst_n asserted while out_valid=1 mid-packet -> out_valid=0 same cycle, first beat after release from channel 0.
